// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - synchronises and debounces the code switches and ENTER button
// Emits one registered enter strobe e per accepted press, with code X frozen on the same edge.
module keypad_entry #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       r,
    input  logic [2:0] sw_in,
    input  logic       btn_in,
    output logic [2:0] X,
    output logic       e
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {HELD, IDLE, FIRE} state_t;

    logic [2:0]       sw_m_q, sw_s_q;
    logic             btn_m_q, btn_s_q;
    logic             btn_db_q, btn_db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q;
    logic [2:0]       x_q;
    logic             e_q;

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            sw_m_q  <= 3'b000;
            sw_s_q  <= 3'b000;
            btn_m_q <= 1'b0;
            btn_s_q <= 1'b0;
        end else begin
            sw_m_q  <= sw_in;
            sw_s_q  <= sw_m_q;
            btn_m_q <= btn_in;
            btn_s_q <= btn_m_q;
        end
    end

    // Any cycle where the synced level matches the accepted one restarts the count.
    always_comb begin
        btn_db_d = btn_db_q;
        cnt_d    = '0;
        if (btn_s_q != btn_db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_db_d = btn_s_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // btn_db resets high so a button held through reset cannot fire.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            btn_db_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            btn_db_q <= btn_db_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q <= HELD;
            x_q     <= 3'b000;
            e_q     <= 1'b0;
        end else begin
            e_q <= 1'b0;
            case (state_q)
                HELD: if (!btn_db_q) state_q <= IDLE;
                IDLE: begin
                    if (btn_db_q) begin
                        state_q <= FIRE;
                        x_q     <= sw_s_q;
                        e_q     <= 1'b1;
                    end
                end
                FIRE:    state_q <= HELD;
                default: state_q <= HELD;
            endcase
        end
    end

    assign X = x_q;
    assign e = e_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - directed self-checking bench for keypad_entry
module tb_keypad_entry;
    logic       clk = 1'b0;
    logic       r = 1'b1;
    logic [2:0] sw_in = 3'b000;
    logic       btn_in = 1'b0;
    logic [2:0] X;
    logic       e;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int e_cnt = 0;
    int last_e_cyc = -1;
    logic [2:0] last_x = 3'b000;
    int base;
    int n_edge;
    bit seen;

    keypad_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clk    (clk),
        .r      (r),
        .sw_in  (sw_in),
        .btn_in (btn_in),
        .X      (X),
        .e      (e)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!r && e) begin
            e_cnt      = e_cnt + 1;
            last_x     = X;
            last_e_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp = n_cmp + 1;
        if (got != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        r = 1'b1;
        #1;
        chk("rst_e", int'(e), 0);
        chk("rst_x", int'(X), 0);
        tick(2);
        r = 1'b0;
    endtask

    initial begin
        // Test 1: reset state, clean press, latency and capture
        tick(1);
        chk("init_e", int'(e), 0);
        chk("init_x", int'(X), 0);
        tick(2);
        r = 1'b0;
        sw_in = 3'b101;
        tick(10);
        btn_in = 1'b1;
        n_edge = cyc + 1;
        tick(5);
        chk("t1_no_early_e", e_cnt, 0);
        tick(7);
        chk("t1_one_e", e_cnt, 1);
        chk("t1_latency", last_e_cyc, n_edge + 6);
        chk("t1_x_at_e", int'(last_x), 5);
        tick(20);
        chk("t1_held_no_more", e_cnt, 1);

        // Test 2: glitches shorter than the debounce window are ignored
        btn_in = 1'b0;
        do_reset();
        tick(10);
        base = e_cnt;
        btn_in = 1'b1; tick(1); btn_in = 1'b0; tick(10);
        btn_in = 1'b1; tick(3); btn_in = 1'b0; tick(10);
        chk("t2_glitch_no_e", e_cnt - base, 0);
        chk("t2_glitch_x", int'(X), 0);
        btn_in = 1'b1; tick(4); btn_in = 1'b0; tick(12);
        chk("t2_min_pulse_e", e_cnt - base, 1);
        chk("t2_min_pulse_x", int'(X), 5);

        // Test 3: switches move during a long hold
        tick(10);
        base = e_cnt;
        sw_in = 3'b101;
        btn_in = 1'b1;
        tick(25);
        sw_in = 3'b011;
        tick(25);
        chk("t3_single_e", e_cnt - base, 1);
        chk("t3_x_kept", int'(X), 5);
        btn_in = 1'b0;
        tick(10);
        chk("t3_release_x", int'(X), 5);
        btn_in = 1'b1;
        tick(15);
        chk("t3_second_e", e_cnt - base, 2);
        chk("t3_new_x", int'(X), 3);

        // Test 4: button held through reset deassertion
        do_reset();
        tick(20);
        base = e_cnt;
        chk("t4_held_no_e", e_cnt - base, 0);
        chk("t4_x_cleared", int'(X), 0);
        btn_in = 1'b0;
        tick(10);
        sw_in = 3'b110;
        tick(3);
        btn_in = 1'b1;
        tick(15);
        chk("t4_fresh_press_e", e_cnt - base, 1);
        chk("t4_fresh_press_x", int'(X), 6);

        // Test 5: reset asserted while e is high
        btn_in = 1'b0;
        tick(12);
        sw_in = 3'b111;
        tick(3);
        btn_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (e) seen = 1'b1;
        end
        chk("t5_e_seen", int'(seen), 1);
        chk("t5_x_before_rst", int'(X), 7);
        #1;
        r = 1'b1;
        #1;
        chk("t5_async_e", int'(e), 0);
        chk("t5_async_x", int'(X), 0);
        @(negedge clk);
        r = 1'b0;
        base = e_cnt;
        tick(20);
        chk("t5_held_no_e", e_cnt - base, 0);
        btn_in = 1'b0;
        tick(10);
        btn_in = 1'b1;
        tick(15);
        chk("t5_repress_e", e_cnt - base, 1);
        chk("t5_repress_x", int'(X), 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
